// File: rtl/layered_color_mapper.sv
// Prioritised sprite-layer merge over a sky/ground background, two-stage pipeline to registered VGA RGB.
// Optional hit-flash mode is built only when LAYERED_COLOR_MAPPER_FLASH_EN is defined.
module layered_color_mapper #(
    parameter int          NUM_LAYERS   = 4,
    parameter logic [23:0] KEY_COLOR    = 24'hFF00FF,
    parameter logic [23:0] SKY_COLOR    = 24'h3FBFFF,
    parameter logic [23:0] GROUND_COLOR = 24'h7F4F1F,
    parameter logic [9:0]  GROUND_Y     = 10'd400,
    parameter int          FLASH_FRAMES = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     pix_en,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [NUM_LAYERS-1:0]    layer_hit,
    input  logic [24*NUM_LAYERS-1:0] layer_color,
    input  logic                     frame_start,
    input  logic                     flash_req,
    output logic [7:0]               VGA_R,
    output logic [7:0]               VGA_G,
    output logic [7:0]               VGA_B,
    output logic                     pix_valid,
    output logic                     flash_active
);

    logic        w_sel_opaque;
    logic [23:0] w_sel_color;
    logic [23:0] w_s2_rgb;
    logic        w_flash;

    logic        r_s1_opaque;
    logic [23:0] r_s1_color;
    logic        r_s1_ground;
    logic        r_v1;
    logic        r_valid;
    logic [23:0] r_rgb;

    // Walk from the lowest priority upward so the lowest qualifying index wins.
    always_comb begin
        w_sel_opaque = 1'b0;
        w_sel_color  = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i] && (layer_color[24*i +: 24] != KEY_COLOR)) begin
                w_sel_opaque = 1'b1;
                w_sel_color  = layer_color[24*i +: 24];
            end
        end
    end

    always_comb begin
        w_s2_rgb = '0;
        if (w_flash) begin
            w_s2_rgb = r_s1_opaque ? 24'hFFFFFF : 24'h000000;
        end else if (r_s1_opaque) begin
            w_s2_rgb = r_s1_color;
        end else begin
            w_s2_rgb = r_s1_ground ? GROUND_COLOR : SKY_COLOR;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_opaque <= 1'b0;
            r_s1_color  <= '0;
            r_s1_ground <= 1'b0;
            r_v1        <= 1'b0;
            r_valid     <= 1'b0;
            r_rgb       <= '0;
        end else if (pix_en) begin
            r_s1_opaque <= w_sel_opaque;
            r_s1_color  <= w_sel_color;
            r_s1_ground <= (DrawY >= GROUND_Y);
            r_v1        <= 1'b1;
            r_valid     <= r_v1;
            r_rgb       <= w_s2_rgb;
        end
    end

`ifdef LAYERED_COLOR_MAPPER_FLASH_EN
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    logic [FW-1:0] r_flash_cnt;

    // A request always reloads the full duration and takes precedence over a frame tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_flash_cnt <= '0;
        end else if (flash_req) begin
            r_flash_cnt <= FW'(FLASH_FRAMES);
        end else if (frame_start && (r_flash_cnt != '0)) begin
            r_flash_cnt <= r_flash_cnt - 1'b1;
        end
    end

    assign w_flash = (r_flash_cnt != '0);

    logic w_unused;
    assign w_unused = ^DrawX;
`else
    assign w_flash = 1'b0;

    logic w_unused;
    assign w_unused = ^{DrawX, flash_req, frame_start};
`endif

    assign VGA_R        = r_rgb[23:16];
    assign VGA_G        = r_rgb[15:8];
    assign VGA_B        = r_rgb[7:0];
    assign pix_valid    = r_valid;
    assign flash_active = w_flash;

endmodule

// File: tb/tb_layered_color_mapper.sv
// Self-checking bench for layered_color_mapper: directed scenarios plus randomized traffic
// compared against a pixel-queue reference model. Follows LAYERED_COLOR_MAPPER_FLASH_EN if defined.
module tb_layered_color_mapper;

    localparam logic [23:0] KEY = 24'hFF00FF;
    localparam logic [23:0] SKY = 24'h3FBFFF;
    localparam logic [23:0] GND = 24'h7F4F1F;
    localparam int          FLASH_LEN = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        flash_req = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [3:0]  layer_hit = '0;
    logic [95:0] layer_color = '0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        pix_valid, flash_active;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of resolved pixels waiting in stage 1, {opaque, colour-or-background}.
    logic [24:0] m_q[$];
    logic [23:0] m_rgb = '0;
    logic        m_valid = 1'b0;
    int          m_beats = 0;
    int          m_cnt = 0;

    always #5 Clk = ~Clk;

    layered_color_mapper #(
        .NUM_LAYERS  (4),
        .KEY_COLOR   (KEY),
        .SKY_COLOR   (SKY),
        .GROUND_COLOR(GND),
        .GROUND_Y    (10'd400),
        .FLASH_FRAMES(FLASH_LEN)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pix_en      (pix_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .layer_hit   (layer_hit),
        .layer_color (layer_color),
        .frame_start (frame_start),
        .flash_req   (flash_req),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .pix_valid   (pix_valid),
        .flash_active(flash_active)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] resolve(input logic [3:0] hit, input logic [95:0] cols,
                                            input logic [9:0] y);
        logic [23:0] c;
        for (int i = 0; i < 4; i++) begin
            c = cols[24*i +: 24];
            if (hit[i] && c != KEY) return {1'b1, c};
        end
        return {1'b0, (y >= 10'd400) ? GND : SKY};
    endfunction

    function automatic logic [95:0] pack4(input logic [23:0] c0, input logic [23:0] c1,
                                          input logic [23:0] c2, input logic [23:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [23:0] rnd_color();
        logic [23:0] c;
        c = 24'($urandom);
        if ($urandom_range(3) == 0) c = KEY;
        return c;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_q.push_back({1'b0, SKY});
        m_rgb   = '0;
        m_valid = 1'b0;
        m_beats = 0;
        m_cnt   = 0;
    endtask

    task automatic step(input logic pen, input logic [3:0] hit, input logic [95:0] cols,
                        input logic [9:0] y, input logic freq, input logic fst);
        logic [24:0] item;
        logic        fl;
        pix_en      = pen;
        layer_hit   = hit;
        layer_color = cols;
        DrawY       = y;
        DrawX       = 10'($urandom);
        flash_req   = freq;
        frame_start = fst;
        @(posedge Clk);
        #1;
        fl = (m_cnt != 0);
        if (pen) begin
            item    = m_q.pop_front();
            m_rgb   = fl ? (item[24] ? 24'hFFFFFF : 24'h000000) : item[23:0];
            m_valid = (m_beats >= 1);
            m_beats++;
            m_q.push_back(resolve(hit, cols, y));
        end
`ifdef LAYERED_COLOR_MAPPER_FLASH_EN
        if (freq) m_cnt = FLASH_LEN;
        else if (fst && m_cnt > 0) m_cnt--;
`endif
        chk("rgb", {VGA_R, VGA_G, VGA_B}, m_rgb);
        chk("pix_valid", 24'(pix_valid), 24'(m_valid));
        chk("flash_active", 24'(flash_active), 24'(m_cnt != 0));
        flash_req   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic rstep(input logic freq, input logic fst);
        step(1'b1, 4'($urandom), pack4(rnd_color(), rnd_color(), rnd_color(), rnd_color()),
             10'($urandom_range(799)), freq, fst);
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        chk("reset_valid", 24'(pix_valid), 24'h0);
        chk("reset_flash", 24'(flash_active), 24'h0);
        #10 Reset_n = 1'b1;

        // First beat after reset shows the cleared stage-1 contents as sky, not yet valid.
        step(1'b1, 4'b0110, pack4(24'h111111, 24'h123456, 24'hABCDEF, 24'h222222), 10'd10, 1'b0, 1'b0);
        chk("first_beat_sky", {VGA_R, VGA_G, VGA_B}, SKY);
        chk("first_beat_invalid", 24'(pix_valid), 24'h0);
        rstep(1'b0, 1'b0);
        chk("priority_rgb", {VGA_R, VGA_G, VGA_B}, 24'h123456);
        chk("priority_valid", 24'(pix_valid), 24'h1);

        step(1'b1, 4'b0001, pack4(KEY, 24'h010203, 24'h040506, 24'h070809), 10'd399, 1'b0, 1'b0);
        step(1'b1, 4'b0001, pack4(KEY, 24'h010203, 24'h040506, 24'h070809), 10'd400, 1'b0, 1'b0);
        chk("key_sky", {VGA_R, VGA_G, VGA_B}, SKY);
        rstep(1'b0, 1'b0);
        chk("key_ground", {VGA_R, VGA_G, VGA_B}, GND);

        // Stall pattern 1,0,0,1,1 with a distinct colour each beat.
        step(1'b1, 4'b0001, pack4(24'hA0A0A0, 0, 0, 0), 10'd5, 1'b0, 1'b0);
        step(1'b0, 4'b0001, pack4(24'hB1B1B1, 0, 0, 0), 10'd5, 1'b0, 1'b0);
        step(1'b0, 4'b0001, pack4(24'hC2C2C2, 0, 0, 0), 10'd5, 1'b0, 1'b0);
        step(1'b1, 4'b0001, pack4(24'hD3D3D3, 0, 0, 0), 10'd5, 1'b0, 1'b0);
        chk("stall_order_a", {VGA_R, VGA_G, VGA_B}, 24'hA0A0A0);
        step(1'b1, 4'b0001, pack4(24'hE4E4E4, 0, 0, 0), 10'd5, 1'b0, 1'b0);
        chk("stall_order_d", {VGA_R, VGA_G, VGA_B}, 24'hD3D3D3);

        // Flash: opaque pixel in stage 1 when the request lands is rendered white.
        step(1'b1, 4'b0001, pack4(24'h123456, 0, 0, 0), 10'd10, 1'b1, 1'b0);
        step(1'b1, 4'b0000, pack4(24'h123456, 0, 0, 0), 10'd450, 1'b0, 1'b0);
`ifdef LAYERED_COLOR_MAPPER_FLASH_EN
        chk("flash_white", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);
        chk("flash_rise", 24'(flash_active), 24'h1);
        rstep(1'b0, 1'b1);
        chk("flash_black", {VGA_R, VGA_G, VGA_B}, 24'h000000);
        rstep(1'b0, 1'b1);
        rstep(1'b0, 1'b0);
        rstep(1'b0, 1'b1);
        chk("flash_hold_3", 24'(flash_active), 24'h1);
        rstep(1'b0, 1'b1);
        chk("flash_fall_4", 24'(flash_active), 24'h0);
        rstep(1'b1, 1'b1);
        chk("flash_load_wins", 24'(flash_active), 24'h1);
        for (int i = 0; i < 3; i++) rstep(1'b0, 1'b1);
        chk("flash_sim_hold", 24'(flash_active), 24'h1);
        rstep(1'b0, 1'b1);
        chk("flash_sim_fall", 24'(flash_active), 24'h0);
`else
        chk("noflash_rgb", {VGA_R, VGA_G, VGA_B}, 24'h123456);
        chk("noflash_inactive", 24'(flash_active), 24'h0);
        rstep(1'b1, 1'b1);
        chk("noflash_ground", {VGA_R, VGA_G, VGA_B}, GND);
        chk("noflash_still_off", 24'(flash_active), 24'h0);
`endif

        // Randomized traffic with stalls, flash requests and frame ticks.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(3) != 0), 4'($urandom),
                 pack4(rnd_color(), rnd_color(), rnd_color(), rnd_color()),
                 10'($urandom_range(799)), ($urandom_range(30) == 0), ($urandom_range(6) == 0));
        end

        // Asynchronous reset mid-stream with a flash pending.
        rstep(1'b1, 1'b0);
        rstep(1'b0, 1'b0);
        #3 Reset_n = 1'b0;
        #1;
        chk("midreset_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        chk("midreset_valid", 24'(pix_valid), 24'h0);
        chk("midreset_flash", 24'(flash_active), 24'h0);
        model_reset();
        @(posedge Clk);
        #3 Reset_n = 1'b1;
        step(1'b1, 4'b0010, pack4(24'h0, 24'h5A5A5A, 24'h0, 24'h0), 10'd20, 1'b0, 1'b0);
        chk("recover_beat1_valid", 24'(pix_valid), 24'h0);
        rstep(1'b0, 1'b0);
        chk("recover_beat2_valid", 24'(pix_valid), 24'h1);
        chk("recover_beat2_rgb", {VGA_R, VGA_G, VGA_B}, 24'h5A5A5A);
        for (int i = 0; i < 40; i++) rstep(($urandom_range(15) == 0), ($urandom_range(3) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layered_color_mapper.md
# layered_color_mapper

Parametrised, pipelined successor to the single-sprite color mapper. Merges `NUM_LAYERS` prioritised sprite layers over a two-band sky/ground background and drives registered VGA RGB. Adds colour-key transparency and a frame-counted "hit flash" mode: background goes black and opaque sprites go white. Sits between the sprite/ROM lookup logic and the VGA DAC outputs.

## Interface

**Parameters**
- `NUM_LAYERS`, 4: number of sprite layers; layer 0 has highest priority.
- `KEY_COLOR`, 24'hFF00FF: RGB value treated as transparent.
- `SKY_COLOR`, 24'h3FBFFF: background colour for `DrawY < GROUND_Y`.
- `GROUND_COLOR`, 24'h7F4F1F: background colour for `DrawY >= GROUND_Y`.
- `GROUND_Y`, 10'd400: first ground scanline.
- `FLASH_FRAMES`, 4: flash duration in frames; must be ≥1.

**Ports**
- `Clk` input 1: sole clock.
- `Reset_n` input 1: asynchronous, active-low reset.
- `pix_en` input 1: pixel strobe; the pipeline advances only when high.
- `DrawX`, `DrawY` input 10 each: current pixel coordinates.
- `layer_hit` input `NUM_LAYERS`: bit i set when layer i covers the pixel.
- `layer_color` input `24*NUM_LAYERS`: layer i RGB at bits `[24*i+23:24*i]`.
- `frame_start` input 1: one-cycle pulse per frame.
- `flash_req` input 1: one-cycle pulse that starts or restarts the flash.
- `VGA_R`, `VGA_G`, `VGA_B` output 8 each: registered pixel colour.
- `pix_valid` output 1: high when the RGB outputs carry a pixel that was accepted 2 `pix_en` beats earlier.
- `flash_active` output 1: flash counter is nonzero.

## Operation
- **Stage 1** (on `pix_en`): select the lowest index i where `layer_hit[i]` is set and `layer_color[i] != KEY_COLOR`.
  - Register `s1_opaque`, `s1_color` and `s1_ground = (DrawY >= GROUND_Y)`.
  - No qualifying layer: `s1_opaque` = 0 and `s1_color` = don't-care.
- **Stage 2** (on `pix_en`), normal mode:
  - RGB = `s1_color` if opaque.
  - Otherwise RGB = GROUND_COLOR or SKY_COLOR, chosen by `s1_ground`.
- **Stage 2**, flash active: opaque → 24'hFFFFFF; not opaque → 24'h000000.
- Flash mode is sampled at stage 2 in the same cycle.
- **Valid pipe**: `v1 <= 1` on `pix_en`; `pix_valid <= v1` on `pix_en`.
- With `pix_en` low, every pipeline register holds its value.
- **Flash counter**, width `$clog2(FLASH_FRAMES+1)`:
  - `flash_req` loads `FLASH_FRAMES`.
  - Otherwise, `frame_start` with a nonzero count decrements it.
  - `flash_req` and `frame_start` in the same cycle: load wins, no decrement.
  - `flash_req` while active: reload, never additive.
  - The counter saturates at 0.
- The flash counter is independent of `pix_en`.
- Layers wider than the hit vector, or X/Y bounds, are not checked; callers gate `layer_hit`.

## Timing
- Reset values:
  - `VGA_R/G/B` = 0, `pix_valid` = 0, `flash_active` = 0.
  - Flash counter = 0; stage-1 registers = 0.
- Latency: 2 `pix_en`-qualified cycles from coordinate/layer inputs to RGB.
- `flash_active` rises the cycle after `flash_req`.
  - Because the flash state is sampled at stage 2, a pixel already in stage 1 sees the new mode.
- Flash lasts exactly `FLASH_FRAMES` `frame_start` pulses after the request.
- Reset asserted mid-frame clears the pipeline and the flash immediately.
  - The first valid pixel appears 2 `pix_en` beats after deassertion.

## Configuration
- `LAYERED_COLOR_MAPPER_FLASH_EN` defined:
  - Flash counter, `flash_req` handling and flash colouring are built.
- Not defined:
  - No counter is built; `flash_active` is tied to 0 and `flash_req` is ignored.
  - Stage 2 always uses normal mode.
  - Ports remain present.

## Test plan
- **Priority**: `NUM_LAYERS`=4, `layer_hit`=4'b0110, layer1=24'h123456, layer2=24'hABCDEF, `pix_en` held high → RGB 12/34/56 two cycles later, `pix_valid`=1.
- **Transparency/background**:
  - `layer_hit`=4'b0001, layer0=KEY_COLOR, DrawY=399 → RGB = SKY_COLOR.
  - Same with DrawY=400 → RGB = GROUND_COLOR.
- **Stall**: toggle `pix_en` 1,0,0,1,1 with distinct colours each accepted beat → outputs change only on `pix_en` beats; order is preserved; no pixel is duplicated or dropped.
- **Flash** (macro defined):
  - Pulse `flash_req`, then 4 `frame_start` pulses.
  - During the flash, opaque pixels → FFFFFF and background → 000000.
  - `flash_active` falls the cycle after the 4th `frame_start`.
  - Simultaneous `flash_req` + `frame_start` → counter = 4.
- **Reset mid-stream**: assert `Reset_n`=0 while active → RGB=0, `pix_valid`=0, `flash_active`=0 asynchronously; recovery after 2 beats.
- **Macro undefined**: `flash_req` pulses → `flash_active` stays 0; colours are unchanged from normal mode.
